// File: rtl/conversor_andar_para_cm.sv
// conversor_andar_para_cm
// Converts a requested floor index into that floor's target height in cm,
// presented as three BCD digits (centenas/dezenas/unidades).
// Height = andar*ALTURA_ANDAR + OFFSET_CM, converted to BCD by a
// 10-iteration shift-add-3 (double-dabble) loop under an iniciar/pronto
// handshake. Start-to-pronto latency is 12 clocks.
//
// Optional build macro CONVERSOR_CM_MEMO_EN: remembers the last successfully
// converted floor; repeating that floor skips the conversion loop and pulses
// pronto after 2 clocks with the digits left as they are.
module conversor_andar_para_cm #(
    parameter int unsigned ALTURA_ANDAR = 30,
    parameter int unsigned OFFSET_CM    = 15,
    parameter int unsigned NUM_ANDARES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] andar,
    output logic [3:0] centenas,
    output logic [3:0] dezenas,
    output logic [3:0] unidades,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CARREGA  = 2'd1,
        CONVERTE = 2'd2,
        FIM      = 2'd3
    } estado_t;

    estado_t     estado, estado_prox;

    logic [1:0]  andar_q;      // floor captured at start, immune to later andar changes
    logic [9:0]  altura;       // binary height, shifted out MSB-first into acc
    logic [11:0] acc;          // three BCD nibbles being built
    logic [11:0] acc_aj;       // acc after the add-3 correction
    logic [3:0]  cnt;          // iteration counter, 0..9
    logic        erro_int;     // error flag of the conversion in progress
    logic        reaproveita;  // conversion skipped: keep the displayed digits

    logic        andar_ok;
    logic [9:0]  altura_calc;
    logic        pula;         // memo hit decided in CARREGA

    assign andar_ok    = (32'(andar_q) < NUM_ANDARES);
    assign altura_calc = 10'(andar_q) * 10'(ALTURA_ANDAR) + 10'(OFFSET_CM);

`ifdef CONVERSOR_CM_MEMO_EN
    logic [1:0]  ultimo_andar;
    logic        valido;

    assign pula = valido && (andar_q == ultimo_andar);
`else
    assign pula = 1'b0;
`endif

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift
    always_comb begin
        acc_aj = acc;
        for (int n = 0; n < 3; n++) begin
            if (acc[4*n +: 4] >= 4'd5)
                acc_aj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    // Next-state logic
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:   if (iniciar) estado_prox = CARREGA;
            CARREGA:  estado_prox = pula ? FIM : CONVERTE;
            CONVERTE: if (cnt == 4'd9) estado_prox = FIM;
            FIM:      estado_prox = OCIOSO;
            default:  estado_prox = OCIOSO;
        endcase
    end

    // Datapath and registered outputs.
    // ocupado is registered so it rises on the edge that leaves CARREGA and
    // falls on the edge that leaves FIM; it is therefore low in the pronto cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            andar_q     <= '0;
            altura      <= '0;
            acc         <= '0;
            cnt         <= '0;
            erro_int    <= 1'b0;
            reaproveita <= 1'b0;
            centenas    <= '0;
            dezenas     <= '0;
            unidades    <= '0;
            pronto      <= 1'b0;
            ocupado     <= 1'b0;
            erro        <= 1'b0;
        end else begin
            pronto  <= 1'b0;
            ocupado <= (estado != OCIOSO) && (estado_prox != OCIOSO);
            case (estado)
                OCIOSO: begin
                    if (iniciar)
                        andar_q <= andar;
                end
                CARREGA: begin
                    altura      <= andar_ok ? altura_calc : '0;
                    erro_int    <= !andar_ok;
                    acc         <= '0;
                    cnt         <= '0;
                    reaproveita <= pula;
                end
                CONVERTE: begin
                    {acc, altura} <= {acc_aj, altura} << 1;
                    cnt           <= cnt + 4'd1;
                end
                FIM: begin
                    if (!reaproveita)
                        {centenas, dezenas, unidades} <= acc;
                    erro   <= erro_int;
                    pronto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CONVERSOR_CM_MEMO_EN
    // Memo of the last good conversion; any error conversion invalidates it
    always_ff @(posedge clock) begin
        if (!reset) begin
            ultimo_andar <= '0;
            valido       <= 1'b0;
        end else if (estado == FIM) begin
            valido <= !erro_int;
            if (!erro_int)
                ultimo_andar <= andar_q;
        end
    end
`endif

endmodule

// File: tb/tb_conversor_andar_para_cm.sv
// Scoreboard bench for conversor_andar_para_cm. Two instances share the
// stimulus: the default configuration and one with NUM_ANDARES=3 so that
// out-of-range floors are reachable. Aware of CONVERSOR_CM_MEMO_EN.
module tb_conversor_andar_para_cm;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] andar;

    logic [3:0] c0, d0, u0, c1, d1, u1;
    logic       p0, o0, e0, p1, o1, e1;

    conversor_andar_para_cm dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .andar(andar),
        .centenas(c0), .dezenas(d0), .unidades(u0),
        .pronto(p0), .ocupado(o0), .erro(e0)
    );

    conversor_andar_para_cm #(.NUM_ANDARES(3)) dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .andar(andar),
        .centenas(c1), .dezenas(d1), .unidades(u1),
        .pronto(p1), .ocupado(o1), .erro(e1)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [3:0] c, d, u;
        logic       e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_cyc = -1;

    // reference-model state per instance
    int         last_start[2];
    int         last_len[2];
    bit         mv[2];
    logic [1:0] ml[2];
    logic [3:0] hc[2], hd[2], hu[2];
    logic       he[2];

    int   m_h, m_na, m_len;
    exp_t m_e;

    task automatic chk(input int i, input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s[inst%0d] cyc %0d: got %0d, want %0d", nm, i, cyc, act, req);
        end
    endtask

    // Model: on each rising edge decide, from the floor arithmetic and the
    // handshake rules, what response each instance owes and when.
    initial begin
        for (int i = 0; i < 2; i++) begin
            last_start[i] = -100; last_len[i] = 0; mv[i] = 0; ml[i] = 0;
            hc[i] = 0; hd[i] = 0; hu[i] = 0; he[i] = 0;
        end
        forever begin
            @(posedge clock);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    last_start[i] = -100;
                    last_len[i]   = 0;
                    mv[i]         = 0;
                    if (i == 0) q0.delete(); else q1.delete();
                    rst_cyc = cyc;
                end else if (iniciar && cyc > last_start[i] + last_len[i]) begin
                    m_na  = (i == 0) ? 4 : 3;
                    m_e.e = (int'(andar) >= m_na);
                    m_h   = m_e.e ? 0 : int'(andar) * 30 + 15;
                    m_e.c = 4'(m_h / 100);
                    m_e.d = 4'((m_h / 10) % 10);
                    m_e.u = 4'(m_h % 10);
                    m_len = 12;
`ifdef CONVERSOR_CM_MEMO_EN
                    if (mv[i] && ml[i] == andar) m_len = 2;
                    mv[i] = !m_e.e;
                    ml[i] = andar;
`endif
                    m_e.due       = cyc + m_len;
                    last_start[i] = cyc;
                    last_len[i]   = m_len;
                    if (i == 0) q0.push_back(m_e); else q1.push_back(m_e);
                end
            end
        end
    end

    task automatic check_inst(input int i, input logic [3:0] c, d, u,
                              input logic p, o, e);
        exp_t f;
        bit   have;
        if (rst_cyc == cyc) begin
            hc[i] = 0; hd[i] = 0; hu[i] = 0; he[i] = 0;
        end
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) f = (i == 0) ? q0[0] : q1[0];
        if (have && f.due <= cyc) begin
            chk(i, "pronto_on_time", int'(p), 1);
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            hc[i] = f.c; hd[i] = f.d; hu[i] = f.u; he[i] = f.e;
        end else begin
            chk(i, "no_extra_pronto", int'(p), 0);
        end
        chk(i, "centenas", int'(c), int'(hc[i]));
        chk(i, "dezenas",  int'(d), int'(hd[i]));
        chk(i, "unidades", int'(u), int'(hu[i]));
        chk(i, "erro",     int'(e), int'(he[i]));
        chk(i, "ocupado",  int'(o),
            int'(cyc >= last_start[i] + 1 && cyc <= last_start[i] + last_len[i] - 1));
    endtask

    // Monitor: sample on the falling edge, pop and compare
    initial begin
        forever begin
            @(negedge clock);
            if (cyc > 0) begin
                check_inst(0, c0, d0, u0, p0, o0, e0);
                check_inst(1, c1, d1, u1, p1, o1, e1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic start(input logic [1:0] a, input int wait_cycles);
        andar = a; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(wait_cycles);
    endtask

    // Stimulus
    initial begin
        reset = 1'b0; iniciar = 1'b0; andar = 2'd0;
        tick(3);
        reset = 1'b1;
        tick(1);
        // single conversion, floor 1 -> 045
        start(2'd1, 14);
        // back-to-back with iniciar held: floor 0 then floor 3
        andar = 2'd0; iniciar = 1'b1;
        tick(1);
        andar = 2'd3;
        tick(24);
        iniciar = 1'b0;
        tick(4);
        // inputs disturbed mid-conversion of floor 2
        start(2'd2, 4);
        andar = 2'd1; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0; andar = 2'd0;
        tick(10);
        // out-of-range on the 3-floor instance, then a good one
        start(2'd3, 13);
        start(2'd2, 13);
        // reset in the middle of a conversion, then a clean run
        start(2'd1, 4);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        start(2'd1, 14);
        // repeated floor (memo path when enabled), then a different one
        start(2'd2, 14);
        start(2'd2, 14);
        start(2'd1, 14);
        // random traffic
        repeat (700) begin
            reset   = ($urandom_range(0, 199) != 0);
            iniciar = ($urandom_range(0, 3) == 0);
            andar   = 2'($urandom_range(0, 3));
            tick(1);
        end
        reset = 1'b1; iniciar = 1'b0;
        tick(20);
        chk(0, "drained", q0.size(), 0);
        chk(1, "drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
